uart_tx_fifo: RTL and testbench

- Memory-mapped UART transmitter that succeeds the single-byte transmitter and sits on the same core request bus (req/we/addr/data).
- Adds a parametrised TX FIFO for back-to-back frames and a runtime baud divisor.
- Adds a runtime frame format: 5–8 data bits, parity none/even/odd, 1 or 2 stop bits.
- Adds sticky overflow and a TX-done interrupt.

---
 rtl/uart_pkg.sv | 61 ++++++
 rtl/sync_fifo.sv | 75 +++++++
 rtl/uart_tx_fifo.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the FIFO-backed UART transmitter: transmit FSM
// states, parity encodings, register byte offsets, CTRL/STATUS bit positions
// and a small helper that masks off data bits beyond the frame length.
// ---------------------------------------------------------------------------
package uart_pkg;

    // Transmit state machine: one state per field of the serial frame.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    // CTRL[3:2] encoding; the reserved code behaves as "no parity".
    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10,
        PAR_RSVD = 2'b11
    } parity_e;

    // Register byte addresses on the core request bus.
    localparam logic [31:0] REG_DATA   = 32'h0000_0000;
    localparam logic [31:0] REG_CTRL   = 32'h0000_0004;
    localparam logic [31:0] REG_STATUS = 32'h0000_0008;
    localparam logic [31:0] REG_DIV    = 32'h0000_000C;

    // CTRL field positions.
    localparam int CTRL_LEN_LSB = 0;
    localparam int CTRL_LEN_MSB = 1;
    localparam int CTRL_PAR_LSB = 2;
    localparam int CTRL_PAR_MSB = 3;
    localparam int CTRL_STOP2   = 4;
    localparam int CTRL_IRQ_EN  = 5;
    localparam int CTRL_W       = 6;

    // Length field value 3 selects 8 data bits, so the reset frame format
    // is 8 data bits, no parity, one stop bit, interrupt disabled.
    localparam logic [CTRL_W-1:0] CTRL_RESET = 6'b00_0011;

    // STATUS bit positions; the FIFO level occupies bits [15:8].
    localparam int STAT_BUSY  = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_EMPTY = 2;
    localparam int STAT_OVF   = 3;

    // Keeps only the bits that actually go on the wire for a length code
    // (0 -> 5 bits ... 3 -> 8 bits).
    function automatic logic [7:0] data_mask(input logic [1:0] len_code);
        return 8'hFF >> (2'd3 - len_code);
    endfunction

    function automatic logic parity_enabled(input parity_e mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with show-ahead read data (data_o always presents the
// oldest entry). No write-to-read bypass: a word pushed into an empty FIFO
// becomes visible the cycle after the push.
//   clk_i, rst_i    clock, asynchronous active-high reset (empties FIFO)
//   push_i, data_i  write strobe and word; ignored while full
//   pop_i, data_o   read strobe and oldest word; pop ignored while empty
//   full_o, empty_o occupancy flags
//   level_o         number of stored entries (0..DEPTH)
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign level_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // Guard the strobes so a push into a full FIFO or a pop from an empty
    // one cannot corrupt the pointers.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage array carries no reset; only the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; the count
    // is kept separately so full and empty are unambiguous.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Memory-mapped UART transmitter with a TX FIFO, runtime baud divisor and
// runtime frame format (5..8 data bits, none/even/odd parity, 1 or 2 stop
// bits), sticky overflow flag and a TX-done interrupt.
//   clk_i, rst_i         clock, asynchronous active-high reset
//   uart_req_i           bus request
//   uart_we_i            1 = write, 0 = read (qualified by uart_req_i)
//   addr_i               register byte address (DATA/CTRL/STATUS/DIV)
//   uart_data_i          write data
//   uart_data_o          combinational read data, 0 when unmapped or idle
//   uart_tx_o            registered serial line, idle high
//   irq_o                registered interrupt: enabled and nothing to send
// ---------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 86
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        uart_req_i,
    input  logic        uart_we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] uart_data_i,
    output logic [31:0] uart_data_o,
    output logic        uart_tx_o,
    output logic        irq_o
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic              wr_en;
    logic              rd_en;
    logic              push_req;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [7:0]        fifo_rdata;
    logic [LW-1:0]     fifo_level;
    logic [8:0]        level_ext;
    logic [7:0]        level_sat;
    logic [31:0]       status_word;

    logic [CTRL_W-1:0] ctrl_q;
    logic [DIV_W-1:0]  div_q;
    logic              overflow_q;
    logic [7:0]        last_byte_q;
    logic              irq_q;
    logic              busy;

    tx_state_e         state_q;
    tx_state_e         state_d;
    logic              tx_q;
    logic              tx_d;
    logic              tick;
    logic              last_bit;
    logic              stop_done;
    logic [DIV_W-1:0]  baud_cnt_q;
    logic [DIV_W-1:0]  f_div_q;
    logic [2:0]        bit_cnt_q;
    logic [1:0]        f_len_q;
    logic              f_par_en_q;
    logic              f_par_bit_q;
    logic              f_two_stop_q;
    logic              stop_cnt_q;
    logic [7:0]        shift_q;
    parity_e           ctrl_par;
    logic              unused_bits;

    assign wr_en    = uart_req_i && uart_we_i;
    assign rd_en    = uart_req_i && !uart_we_i;
    assign push_req = wr_en && (addr_i == REG_DATA);
    assign ctrl_par = parity_e'(ctrl_q[CTRL_PAR_MSB:CTRL_PAR_LSB]);
    assign busy     = (state_q != ST_IDLE) || !fifo_empty;

    // Upper write-data bits only matter for some registers.
    assign unused_bits = ^uart_data_i[31:8];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_req),
        .pop_i   (fifo_pop),
        .data_i  (uart_data_i[7:0]),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // Configuration registers and the sticky overflow flag. A DATA write
    // that finds the FIFO full sets overflow; if that coincides with a
    // clear request, the new overflow event wins.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl_q     <= CTRL_RESET;
            div_q      <= DIV_W'(DEFAULT_DIV);
            overflow_q <= 1'b0;
        end else begin
            if (wr_en && (addr_i == REG_CTRL)) begin
                ctrl_q <= uart_data_i[CTRL_W-1:0];
            end
            if (wr_en && (addr_i == REG_DIV)) begin
                div_q <= (uart_data_i[DIV_W-1:0] == '0) ? DIV_W'(1)
                                                        : uart_data_i[DIV_W-1:0];
            end
            if (push_req && fifo_full) begin
                overflow_q <= 1'b1;
            end else if (wr_en && (addr_i == REG_STATUS) && uart_data_i[STAT_OVF]) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // One bit period is complete when the counter reaches the divisor
    // latched for this frame, giving exactly DIV+1 cycles per bit.
    assign tick      = (baud_cnt_q == f_div_q);
    assign last_bit  = (bit_cnt_q == ({1'b0, f_len_q} + 3'd4));
    assign stop_done = tick && (!f_two_stop_q || stop_cnt_q);

    // FSM state register and the registered serial line.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
        end
    end

    // Next state and next line level. The line value for the field being
    // entered is computed here so it appears on the same edge as the state
    // change. Popping the FIFO also loads a new frame, either from IDLE or
    // straight out of STOP so queued frames run without an idle gap.
    always_comb begin
        state_d  = state_q;
        tx_d     = tx_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    tx_d     = 1'b0;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    tx_d    = shift_q[0];
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (!last_bit) begin
                        tx_d = shift_q[1];
                    end else if (f_par_en_q) begin
                        tx_d    = f_par_bit_q;
                        state_d = ST_PARITY;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    tx_d    = 1'b1;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (stop_done) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        tx_d     = 1'b0;
                        state_d  = ST_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Frame datapath. On a pop the byte and a snapshot of CTRL/DIV are
    // captured so register writes during a frame only affect later frames.
    // The parity bit is precomputed from the bits that will actually be
    // sent, which is why unused upper data bits never influence it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            baud_cnt_q   <= '0;
            f_div_q      <= '0;
            bit_cnt_q    <= '0;
            f_len_q      <= '0;
            f_par_en_q   <= 1'b0;
            f_par_bit_q  <= 1'b0;
            f_two_stop_q <= 1'b0;
            stop_cnt_q   <= 1'b0;
            shift_q      <= '0;
            last_byte_q  <= '0;
        end else if (fifo_pop) begin
            baud_cnt_q   <= '0;
            f_div_q      <= div_q;
            bit_cnt_q    <= '0;
            f_len_q      <= ctrl_q[CTRL_LEN_MSB:CTRL_LEN_LSB];
            f_par_en_q   <= parity_enabled(ctrl_par);
            f_par_bit_q  <= (^(fifo_rdata & data_mask(ctrl_q[CTRL_LEN_MSB:CTRL_LEN_LSB])))
                            ^ (ctrl_par == PAR_ODD);
            f_two_stop_q <= ctrl_q[CTRL_STOP2];
            stop_cnt_q   <= 1'b0;
            shift_q      <= fifo_rdata;
            last_byte_q  <= fifo_rdata;
        end else if (state_q != ST_IDLE) begin
            if (tick) begin
                baud_cnt_q <= '0;
                if (state_q == ST_DATA) begin
                    shift_q   <= shift_q >> 1;
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                end
                if (state_q == ST_STOP) begin
                    stop_cnt_q <= 1'b1;
                end
            end else begin
                baud_cnt_q <= baud_cnt_q + DIV_W'(1);
            end
        end
    end

    // Interrupt follows "enabled and nothing left to send" one cycle late.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= ctrl_q[CTRL_IRQ_EN] && !busy;
        end
    end

    // The level field is 8 bits wide, so a 256-deep FIFO saturates at 255.
    assign level_ext = 9'(fifo_level);
    assign level_sat = level_ext[8] ? 8'hFF : level_ext[7:0];

    always_comb begin
        status_word             = '0;
        status_word[STAT_BUSY]  = busy;
        status_word[STAT_FULL]  = fifo_full;
        status_word[STAT_EMPTY] = fifo_empty;
        status_word[STAT_OVF]   = overflow_q;
        status_word[15:8]       = level_sat;
    end

    // Read mux; reads have no side effects.
    always_comb begin
        uart_data_o = '0;
        if (rd_en) begin
            if (addr_i == REG_DATA) begin
                uart_data_o = {24'h0, last_byte_q};
            end else if (addr_i == REG_CTRL) begin
                uart_data_o = 32'(ctrl_q);
            end else if (addr_i == REG_STATUS) begin
                uart_data_o = status_word;
            end else if (addr_i == REG_DIV) begin
                uart_data_o = 32'(div_q);
            end
        end
    end

    assign uart_tx_o = tx_q;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
// Scoreboard bench for uart_tx_fifo: every DATA write pushes the expected
// per-cycle line levels of its frame into a queue, and a monitor pops one
// entry per clock and compares it with the serial line.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam logic [31:0] A_DATA   = 32'h0;
    localparam logic [31:0] A_CTRL   = 32'h4;
    localparam logic [31:0] A_STATUS = 32'h8;
    localparam logic [31:0] A_DIV    = 32'hC;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        uart_req_i;
    logic        uart_we_i;
    logic [31:0] addr_i;
    logic [31:0] uart_data_i;
    logic [31:0] uart_data_o;
    logic        uart_tx_o;
    logic        irq_o;

    int          errCount   = 0;
    int          checkCount = 0;
    bit          expQ[$];
    bit          monEnable  = 1'b0;
    logic [5:0]  benchCtrl;
    int          benchDiv;
    logic [31:0] rdata;

    uart_tx_fifo #(
        .FIFO_DEPTH  (DEPTH),
        .DIV_W       (16),
        .DEFAULT_DIV (86)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .uart_req_i  (uart_req_i),
        .uart_we_i   (uart_we_i),
        .addr_i      (addr_i),
        .uart_data_i (uart_data_i),
        .uart_data_o (uart_data_o),
        .uart_tx_o   (uart_tx_o),
        .irq_o       (irq_o)
    );

    always #5 clk_i = ~clk_i;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bus write occupying one clock; returns 1ns after the sampling edge.
    task automatic writeReg(input logic [31:0] a, input logic [31:0] d);
        uart_req_i  = 1'b1;
        uart_we_i   = 1'b1;
        addr_i      = a;
        uart_data_i = d;
        @(posedge clk_i);
        #1;
        uart_req_i  = 1'b0;
        uart_we_i   = 1'b0;
    endtask

    // Combinational read sampled between clock edges.
    task automatic readReg(input logic [31:0] a, output logic [31:0] d);
        uart_req_i = 1'b1;
        uart_we_i  = 1'b0;
        addr_i     = a;
        #1;
        d          = uart_data_o;
        uart_req_i = 1'b0;
    endtask

    task automatic pushBits(input bit v, input int n);
        for (int k = 0; k < n; k++) expQ.push_back(v);
    endtask

    // Writes one byte to DATA. If accepted, the frame it must produce is
    // appended to the scoreboard using the bench's own copy of CTRL/DIV.
    // With nothing queued the line stays high for the cycle of the write
    // and the following one before the start bit appears.
    task automatic applyStimulus(input logic [7:0] b, input bit accepted);
        int per;
        int n;
        bit p;
        if (accepted) begin
            per = benchDiv + 1;
            n   = int'(benchCtrl[1:0]) + 5;
            if (expQ.size() == 0) pushBits(1'b1, 2);
            pushBits(1'b0, per);
            for (int i = 0; i < n; i++) pushBits(b[i], per);
            if (benchCtrl[3:2] == 2'b01 || benchCtrl[3:2] == 2'b10) begin
                p = 1'b0;
                for (int i = 0; i < n; i++) p = p ^ b[i];
                if (benchCtrl[3:2] == 2'b10) p = ~p;
                pushBits(p, per);
            end
            pushBits(1'b1, per * (benchCtrl[4] ? 2 : 1));
        end
        writeReg(A_DATA, {24'h0, b});
    endtask

    // Waits (bounded) until every expected line cycle has been compared.
    task automatic waitDrain(input int maxCycles);
        int c = 0;
        while (expQ.size() != 0 && c < maxCycles) begin
            @(posedge clk_i);
            c++;
        end
        checkOutput("drain_remaining", 32'(expQ.size()), 32'd0);
        expQ.delete();
        repeat (3) @(posedge clk_i);
        #1;
    endtask

    // Line monitor: one comparison per clock, idle-high when nothing queued.
    initial begin
        bit e;
        forever begin
            @(negedge clk_i);
            if (monEnable) begin
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    checkOutput("line", {31'b0, uart_tx_o}, {31'b0, e});
                end else begin
                    checkOutput("line_idle", {31'b0, uart_tx_o}, 32'd1);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_i       = 1'b1;
        uart_req_i  = 1'b0;
        uart_we_i   = 1'b0;
        addr_i      = '0;
        uart_data_i = '0;
        benchCtrl   = 6'h03;
        benchDiv    = 86;

        // Reset values
        #12;
        checkOutput("rst_line", {31'b0, uart_tx_o}, 32'd1);
        checkOutput("rst_irq", {31'b0, irq_o}, 32'd0);
        #10;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        readReg(A_STATUS, rdata);
        checkOutput("rst_status", rdata, 32'h0000_0004);
        readReg(A_DIV, rdata);
        checkOutput("rst_div", rdata, 32'd86);
        readReg(32'h10, rdata);
        checkOutput("unmapped_read", rdata, 32'd0);
        monEnable = 1'b1;

        // A written divisor of 0 is stored as 1
        writeReg(A_DIV, 32'd0);
        readReg(A_DIV, rdata);
        checkOutput("div_zero", rdata, 32'd1);
        writeReg(A_DIV, 32'd3);
        benchDiv = 3;

        // 8N1, 0x55
        writeReg(A_CTRL, 32'h03);
        benchCtrl = 6'h03;
        applyStimulus(8'h55, 1'b1);
        waitDrain(200);
        readReg(A_STATUS, rdata);
        checkOutput("idle_status", rdata, 32'h0000_0004);
        readReg(A_DATA, rdata);
        checkOutput("last_byte_55", rdata, 32'h55);

        // 8 bits, even parity, 2 stop bits
        writeReg(A_CTRL, 32'h17);
        benchCtrl = 6'h17;
        applyStimulus(8'h07, 1'b1);
        waitDrain(200);
        readReg(A_DATA, rdata);
        checkOutput("last_byte_07", rdata, 32'h07);

        // 5 bits, odd parity, upper bits ignored
        writeReg(A_CTRL, 32'h08);
        benchCtrl = 6'h08;
        applyStimulus(8'hFF, 1'b1);
        waitDrain(200);

        // CTRL change while a frame is in flight only affects the next one
        writeReg(A_CTRL, 32'h03);
        benchCtrl = 6'h03;
        applyStimulus(8'h3C, 1'b1);
        writeReg(A_CTRL, 32'h08);
        benchCtrl = 6'h08;
        applyStimulus(8'hA6, 1'b1);
        waitDrain(300);

        // Overflow: DEPTH+2 back-to-back writes, the last one rejected
        writeReg(A_CTRL, 32'h03);
        benchCtrl = 6'h03;
        for (int i = 0; i < DEPTH + 2; i++) begin
            applyStimulus(8'(i * 13 + 1), (i <= DEPTH));
        end
        readReg(A_STATUS, rdata);
        checkOutput("ovf_full_status", rdata, {16'h0, 8'(DEPTH), 8'h0B});
        repeat (30) @(posedge clk_i);
        #1;
        readReg(A_STATUS, rdata);
        checkOutput("ovf_after_pop", rdata, {16'h0, 8'(DEPTH - 1), 8'h09});
        writeReg(A_STATUS, 32'h8);
        readReg(A_STATUS, rdata);
        checkOutput("ovf_cleared", rdata, {16'h0, 8'(DEPTH - 1), 8'h01});
        waitDrain(2000);

        // Interrupt behaviour
        writeReg(A_CTRL, 32'h23);
        benchCtrl = 6'h23;
        @(posedge clk_i);
        #1;
        checkOutput("irq_enabled_idle", {31'b0, irq_o}, 32'd1);
        applyStimulus(8'h5A, 1'b1);
        repeat (40) @(posedge clk_i);
        #1;
        readReg(A_STATUS, rdata);
        checkOutput("irq_busy_last_cycle", {31'b0, rdata[0]}, 32'd1);
        checkOutput("irq_low_while_busy", {31'b0, irq_o}, 32'd0);
        @(posedge clk_i);
        #1;
        readReg(A_STATUS, rdata);
        checkOutput("irq_busy_fell", {31'b0, rdata[0]}, 32'd0);
        checkOutput("irq_not_yet", {31'b0, irq_o}, 32'd0);
        @(posedge clk_i);
        #1;
        checkOutput("irq_rise", {31'b0, irq_o}, 32'd1);
        writeReg(A_CTRL, 32'h03);
        benchCtrl = 6'h03;
        checkOutput("irq_hold", {31'b0, irq_o}, 32'd1);
        @(posedge clk_i);
        #1;
        checkOutput("irq_disabled", {31'b0, irq_o}, 32'd0);
        waitDrain(50);

        // Asynchronous reset in the middle of a data bit
        applyStimulus(8'h00, 1'b1);
        repeat (7) @(posedge clk_i);
        #2;
        checkOutput("pre_rst_line", {31'b0, uart_tx_o}, 32'd0);
        monEnable = 1'b0;
        rst_i = 1'b1;
        #1;
        checkOutput("async_rst_line", {31'b0, uart_tx_o}, 32'd1);
        checkOutput("async_rst_irq", {31'b0, irq_o}, 32'd0);
        expQ.delete();
        readReg(A_STATUS, rdata);
        checkOutput("async_rst_status", rdata, 32'h0000_0004);
        readReg(A_DIV, rdata);
        checkOutput("async_rst_div", rdata, 32'd86);
        @(negedge clk_i);
        rst_i = 1'b0;
        benchDiv = 86;
        @(posedge clk_i);
        #1;
        monEnable = 1'b1;

        // Transmitter recovers after reset
        writeReg(A_DIV, 32'd3);
        benchDiv = 3;
        applyStimulus(8'hC3, 1'b1);
        waitDrain(200);
        readReg(A_DATA, rdata);
        checkOutput("post_rst_byte", rdata, 32'hC3);

        monEnable = 1'b0;
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
